// File: rtl/board_gpio_ctrl.sv
// board_gpio_ctrl
//   Board I/O front-end between raw FPGA-board pins and the 32-bit GPIO ports
//   of the processor subsystem. Each switch and button bit is synchronised
//   (2 flops) and debounced. Button presses are latched into sticky flags.
//   The LEDs are driven from the CPU output word, with optional PWM dimming.
//
//   Optional feature macro: BOARD_GPIO_PWM_EN
//     defined   - the LED pattern is gated by an 8-bit PWM whose duty comes
//                 from gpio_bo_i[23:16]
//     undefined - led_o is gpio_bo_i[LED_W-1:0], registered
//
//   Ports
//     clk_i        system clock
//     arst_i       asynchronous active-high reset
//     sw_i         raw switch pins (asynchronous)
//     btn_i        raw button pins (asynchronous)
//     press_clr_i  one-cycle clear strobes for the press flags
//     gpio_bo_i    CPU output word: [LED_W-1:0] LED pattern, [23:16] duty
//     gpio_bi_o    CPU input word: {0, press flags, btn_db, sw_db}
//     led_o        LED pins (registered)
module board_gpio_ctrl #(
  parameter int unsigned SW_W       = 8,
  parameter int unsigned BTN_W      = 4,
  parameter int unsigned LED_W      = 8,
  parameter int unsigned DEB_CYCLES = 20000,
  parameter int unsigned PWM_DIV    = 64
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [SW_W-1:0]   sw_i,
  input  logic [BTN_W-1:0]  btn_i,
  input  logic [BTN_W-1:0]  press_clr_i,
  input  logic [31:0]       gpio_bo_i,
  output logic [31:0]       gpio_bi_o,
  output logic [LED_W-1:0]  led_o
);

  if (SW_W < 1 || SW_W > 16 || BTN_W < 1 || BTN_W > 8 || SW_W + 2 * BTN_W > 32 ||
      LED_W < 1 || LED_W > 16 || DEB_CYCLES < 2 || PWM_DIV < 1) begin : g_param_err
    $error("board_gpio_ctrl: illegal parameter combination");
  end

  localparam int unsigned IN_W  = SW_W + BTN_W;
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Switches and buttons share one synchroniser/debouncer vector.
  // Switches occupy the low bits and buttons the high bits.
  logic [IN_W-1:0]  sync1, sync2, db;
  logic [DEB_W-1:0] cnt [IN_W];
  logic [BTN_W-1:0] btn_db, btn_db_d, press;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int unsigned i = 0; i < IN_W; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {btn_i, sw_i};
      sync2 <= sync1;
      for (int unsigned i = 0; i < IN_W; i++) begin
        if (sync2[i] != db[i]) begin
          if (cnt[i] == DEB_LAST) begin
            db[i]  <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          // Any return to the stable value restarts the qualification window.
          cnt[i] <= '0;
        end
      end
    end
  end

  assign btn_db = db[IN_W-1:SW_W];

  // A rising debounced level sets a flag; set takes priority over clear.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      btn_db_d <= '0;
      press    <= '0;
    end else begin
      btn_db_d <= btn_db;
      press    <= (press & ~press_clr_i) | (btn_db & ~btn_db_d);
    end
  end

  always_comb begin
    gpio_bi_o = '0;
    gpio_bi_o[IN_W-1:0]    = db;
    gpio_bi_o[IN_W +: BTN_W] = press;
  end

  // Not every bit of the CPU output word drives something.
  logic unused_bo;
  assign unused_bo = ^gpio_bo_i;

`ifdef BOARD_GPIO_PWM_EN
  localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic [7:0]       pwm_cnt;
  logic [7:0]       duty;
  logic             pwm_on;

  // Duty is taken live from the bus, so a change applies on the next LED update.
  assign duty   = gpio_bo_i[23:16];
  assign pwm_on = (duty == 8'hFF) || (pwm_cnt < duty);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pre     <= '0;
      pwm_cnt <= '0;
      led_o   <= '0;
    end else begin
      if (pre == PRE_LAST) begin
        pre     <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        pre <= pre + 1'b1;
      end
      led_o <= gpio_bo_i[LED_W-1:0] & {LED_W{pwm_on}};
    end
  end
`else
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) led_o <= '0;
    else        led_o <= gpio_bo_i[LED_W-1:0];
  end
`endif

endmodule
